// File: rtl/serial_negate.sv
// Bit-serial one's/two's complement unit: one operand bit per clock, LSB first,
// through a single carry flop. Result, zero and overflow are registered on the last bit.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready high
// SHIFT | consuming one operand bit per cycle, LSB first
// DONE  | result presented; holds until out_ready
module serial_negate #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         zero,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state, state_nxt;
    logic [N-1:0]   op_sr;
    logic [N-2:0]   res_sr;
    logic [N-1:0]   res_final;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic           mode_q;
    logic           bit_inv;
    logic           bit_res;
    logic           last_bit;

    assign bit_inv   = ~op_sr[0];
    assign bit_res   = bit_inv ^ carry;
    assign res_final = {bit_res, res_sr};
    assign last_bit  = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // out_data is loaded only on the last bit, so no partial result is ever visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sr    <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            mode_q   <= 1'b0;
            out_data <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_sr  <= in_data;
                        mode_q <= mode;
                        carry  <= mode;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    carry  <= bit_inv & carry;
                    op_sr  <= {1'b0, op_sr[N-1:1]};
                    res_sr <= res_final[N-1:1];
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        out_data <= res_final;
                        zero     <= (res_final == '0);
                        // op_sr[0] is the original MSB on the last bit
                        overflow <= mode_q & op_sr[0] & bit_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negate.sv
// Directed bench for serial_negate: corner cases, backpressure, mid-operation reset
// and back-to-back streaming against a ~x / -x reference.
module tb_serial_negate;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          zero;
    logic          overflow;

    int n_total;
    int n_pass;

    serial_negate #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  out_data,       32'h0000_0000);
        check({tag, "_zero"},      32'(zero),      32'd0);
        check({tag, "_overflow"},  32'(overflow),  32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Offer an operand and return #1 after the accept edge.
    task automatic start_op(input logic m, input logic [N-1:0] d);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = ~m;
        in_data  = ~d;
    endtask

    // Called #1 after the accept edge; measures latency, checks result, completes handshake.
    task automatic finish_op(input string tag, input logic [N-1:0] exp_d,
                             input logic exp_z, input logic exp_o);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"},  32'(lat),       32'(N));
        check({tag, "_data"},     out_data,       exp_d);
        check({tag, "_zero"},     32'(zero),      32'(exp_z));
        check({tag, "_overflow"}, 32'(overflow),  32'(exp_o));
        check({tag, "_ready_lo"}, 32'(in_ready),  32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"},       32'(in_ready),  32'd1);
        check({tag, "_data_hold"},  out_data,       exp_d);
    endtask

    logic [N-1:0] s_data [8];
    logic         s_mode [8];
    logic [N-1:0] s_exp;
    time          acc_t, prev_t;
    int           k;

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        in_data   = '0;

        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        start_op(1'b0, 32'h0000_00FF);
        finish_op("ones_ff", 32'hFFFF_FF00, 1'b0, 1'b0);

        start_op(1'b0, 32'hFFFF_FFFF);
        finish_op("ones_allones", 32'h0000_0000, 1'b1, 1'b0);

        start_op(1'b1, 32'h0000_0001);
        finish_op("neg_1", 32'hFFFF_FFFF, 1'b0, 1'b0);

        start_op(1'b1, 32'h0000_0000);
        finish_op("neg_0", 32'h0000_0000, 1'b1, 1'b0);

        start_op(1'b1, 32'h7FFF_FFFF);
        finish_op("neg_max", 32'h8000_0001, 1'b0, 1'b0);

        start_op(1'b1, 32'h8000_0000);
        finish_op("neg_min", 32'h8000_0000, 1'b0, 1'b1);

        // out_data/overflow are non-zero here, so the abort must visibly clear them
        start_op(1'b1, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("abort_held");
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 32'hA5A5_A5A5);
        finish_op("after_abort", 32'h5A5A_5A5A, 1'b0, 1'b0);

        // Backpressure with a competing operand offered throughout the hold
        start_op(1'b1, 32'h1234_5678);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_latency", 32'(k), 32'(N));
        in_valid = 1'b1;
        mode     = 1'b0;
        in_data  = 32'h0F0F_0F0F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_data",  out_data,        32'hEDCB_A988);
            check("bp_ready", 32'(in_ready),   32'd0);
            check("bp_valid", 32'(out_valid),  32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_held_accepted", 32'(in_ready), 32'd0);
        finish_op("bp_next", 32'hF0F0_F0F0, 1'b0, 1'b0);

        // Streaming: in_valid and out_ready held high
        for (int i = 0; i < 8; i++) begin
            s_data[i] = $urandom;
            s_mode[i] = 1'($urandom_range(0, 1));
        end
        s_data[3] = 32'h8000_0000;
        s_mode[3] = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = s_data[0];
        mode      = s_mode[0];
        prev_t    = 0;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!in_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("st_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            acc_t = $time;
            #1;
            if (i < 7) begin
                in_data = s_data[i+1];
                mode    = s_mode[i+1];
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                check("st_interval", 32'((acc_t - prev_t) / 10), 32'(N + 2));
            end
            prev_t = acc_t;
            k = 0;
            while (!out_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            s_exp = s_mode[i] ? (~s_data[i] + 32'd1) : ~s_data[i];
            check("st_data",     out_data,       s_exp);
            check("st_zero",     32'(zero),      32'(s_exp == 32'd0));
            check("st_overflow", 32'(overflow),
                  32'(s_mode[i] && (s_data[i] == 32'h8000_0000)));
            @(negedge clk);
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_negate.md
# serial_negate

Bit-serial complement unit for the ALU datapath. Accepts one N-bit operand over a valid/ready handshake and produces either its one's complement (bitwise inverse) or its two's complement (arithmetic negation). It processes one bit per clock, LSB first, through a single carry flop. It is the low-area, multi-cycle alternative to the parallel inverter array and feeds the subtract/negate path when area matters more than latency.

## Interface
- N, 32, operand/result width; legal range N >= 2
- CW, $clog2(N), bit-counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept; high exactly when state == IDLE
- mode  input  1  0 = one's complement (~x), 1 = two's complement (-x); sampled with in_data on accept
- in_data  input  N  operand
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  N  result, registered
- zero  output  1  out_data == 0; registered; valid while out_valid
- overflow  output  1  mode=1 and operand was the most negative value (1 followed by N-1 zeros); registered; valid while out_valid

## Operation
- States: IDLE, SHIFT, DONE; 2-bit state register.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load operand shift register, latch mode, set carry=mode, clear bit counter, go to SHIFT.
- SHIFT: one bit per cycle.
  - b = ~op[0]; r = b ^ carry; carry <= b & carry.
  - Operand shifts right.
  - Result register shifts right with r entering at bit N-1.
  - Counter increments.
- Last SHIFT cycle (counter == N-1):
  - Register zero from the final result.
  - Register overflow = mode & op_msb & r, where op_msb is the original operand MSB, i.e. the bit consumed this cycle.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data, zero and overflow are held stable.
  - On out_ready, go to IDLE. out_valid drops on the same edge. out_data keeps its value until the next result overwrites it.
- Carry out of bit N-1 is discarded. Arithmetic is modulo 2^N.
- mode=1 with operand 0 gives result 0, zero=1, overflow=0.
- mode=0 with operand all-ones gives 0, zero=1, overflow=0.
- overflow is always 0 when mode=0.
- in_data and mode are ignored outside the accept edge. in_valid asserted while in SHIFT or DONE has no effect.
- out_ready outside DONE has no effect.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - out_valid=0, out_data=0, zero=0, overflow=0.
  - carry=0, counter=0, internal shift registers=0.
  - in_ready=1, both during and after reset.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately. No partial result is ever presented. The first accept after release is valid.
- Latency:
  - The accept edge is edge 0.
  - Bit i is processed on edge i+1.
  - The DONE state is entered on edge N, so out_valid is high in the cycle after edge N.
- Minimum issue interval is N+2 cycles: accept, N shift cycles, one DONE cycle with out_ready=1, then the next accept in IDLE.
- in_ready is a combinational decode of the state register. No combinational path exists from in_valid or out_ready to any output.
- Backpressure: DONE holds indefinitely. in_ready stays 0 for the whole hold.

## Test plan
- Reset check: drive rst_n=0 mid-run, then release.
  - Required: out_valid=0, out_data=0x00000000, zero=0, overflow=0, in_ready=1 immediately on assertion.
- One's complement, N=32: mode=0, in_data=0x000000FF.
  - Required: out_valid rises N cycles after the accept edge.
  - out_data=0xFFFFFF00, zero=0, overflow=0.
- Two's complement corner cases, mode=1:
  - 0x00000001 -> 0xFFFFFFFF, ovf 0.
  - 0x00000000 -> 0x00000000, zero 1.
  - 0x80000000 -> 0x80000000, overflow 1.
  - 0x7FFFFFFF -> 0x80000001, ovf 0.
- Backpressure: after the result for 0x12345678 (mode=1) appears, hold out_ready=0 for 5 cycles while in_valid=1 with different data.
  - Required: out_data stays 0xEDCBA988, in_ready=0 throughout.
  - The held input is accepted only after the out handshake completes and the block returns to IDLE.
- Reset mid-SHIFT: assert rst_n=0 on cycle 10 of a 32-cycle operation.
  - Required: all outputs at reset values.
  - Next operation (mode=0, 0xA5A5A5A5) returns 0x5A5A5A5A with correct latency.
- Back-to-back streaming: in_valid and out_ready held at 1, 8 random operands with random mode.
  - Required: every result matches the ~x or -x model.
  - Consecutive accepts are exactly N+2 cycles apart.
